// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   u32/u64            : word aliases
//   fetch_state_t      : FETCH / HOLD / FLUSH
//   fetch_data_t       : fetch-to-decode register {valid, pc, raw_instr}
//   ibus_req_t/resp_t  : instruction bus request/response bundles
//   pc_sel_t           : next-pc source chosen by fetch_pcselect
//   PC_RESET           : default reset PC
package fetch_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u64 PC_RESET = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   raw_instr;
    } fetch_data_t;

    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic data_ok;
        u32   data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2,
        PC_PENDING  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/fetch_pcselect.sv
// fetch_pcselect: combinational next-PC chooser for the fetch stage.
//   state       : current fetch FSM state
//   req_active  : a bus request is currently being presented
//   data_ok     : bus response completes this cycle
//   redirect    : branch/jump redirect this cycle
//   out_ready   : decode accepts the presented instruction
//   pc          : current PC
//   pending_pc  : redirect target remembered while flushing
//   redirect_pc : redirect target, already word-aligned
//   pc_next     : PC value for the next cycle
module fetch_pcselect
    import fetch_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  fetch_state_t    state,
    input  logic            req_active,
    input  logic            data_ok,
    input  logic            redirect,
    input  logic            out_ready,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pending_pc,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc_next
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(3'd4);

    pc_sel_t sel_s;

    // Pick the PC source from the state and this cycle's events.
    always_comb begin
        sel_s = PC_HOLD;
        case (state)
            FETCH: begin
                // With a request out, a redirect only retargets immediately when
                // the response lands the same cycle; otherwise FLUSH holds the
                // old address until the bus completes.
                if (redirect && (data_ok || !req_active)) begin
                    sel_s = PC_REDIRECT;
                end else begin
                    sel_s = PC_HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    sel_s = PC_REDIRECT;
                end else if (out_ready) begin
                    sel_s = PC_INC;
                end else begin
                    sel_s = PC_HOLD;
                end
            end
            FLUSH: begin
                if (req_active && data_ok) begin
                    sel_s = redirect ? PC_REDIRECT : PC_PENDING;
                end else begin
                    sel_s = PC_HOLD;
                end
            end
            default: sel_s = PC_HOLD;
        endcase
    end

    // Next-PC multiplexer; pc + 4 wraps naturally at PC_W bits.
    always_comb begin
        pc_next = pc;
        case (sel_s)
            PC_HOLD:     pc_next = pc;
            PC_INC:      pc_next = pc + PC_STEP;
            PC_REDIRECT: pc_next = redirect_pc;
            PC_PENDING:  pc_next = pending_pc;
            default:     pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage. Owns the PC, issues one outstanding read at a
// time on the instruction bus and hands {pc, instr} to decode via valid/ready.
// Redirects never let a wrong-path instruction reach decode.
//   clk, resetn                 : clock, asynchronous active-low reset
//   ireq_valid, ireq_addr       : instruction bus request (held until data_ok)
//   iresp_data_ok, iresp_data   : instruction bus response
//   redirect_valid, redirect_pc : branch/jump redirect
//   out_valid, out_ready        : decode handshake
//   out_pc, out_instr           : presented PC and raw instruction word
module fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET,
    parameter int          PC_W     = 64
) (
    input  logic            clk,
    input  logic            resetn,
    output logic            ireq_valid,
    output logic [PC_W-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam logic [PC_W-1:0] PC_INIT = RESET_PC[PC_W-1:0];

    fetch_state_t    state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pending_r;
    logic            ireq_valid_r;
    fetch_data_t     out_r;
    ibus_resp_t      iresp_s;
    logic [PC_W-1:0] redirect_al_s;
    logic [PC_W-1:0] pc_next_s;

    assign iresp_s       = '{data_ok: iresp_data_ok, data: iresp_data};
    assign redirect_al_s = {redirect_pc[PC_W-1:2], 2'b00};

    fetch_pcselect #(.PC_W(PC_W)) u_pcselect (
        .state       (state_r),
        .req_active  (ireq_valid_r),
        .data_ok     (iresp_s.data_ok),
        .redirect    (redirect_valid),
        .out_ready   (out_ready),
        .pc          (pc_r),
        .pending_pc  (pending_r),
        .redirect_pc (redirect_al_s),
        .pc_next     (pc_next_s)
    );

    // Fetch FSM; ireq_valid and the decode register are set from the next state.
    // ireq_valid stays low for the first cycle after reset, so data_ok is only
    // honoured once a request has actually been presented.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= FETCH;
            pc_r         <= PC_INIT;
            pending_r    <= PC_INIT;
            ireq_valid_r <= 1'b0;
            out_r        <= '0;
        end else begin
            pc_r <= pc_next_s;
            case (state_r)
                FETCH: begin
                    if (ireq_valid_r && iresp_s.data_ok && !redirect_valid) begin
                        out_r.valid     <= 1'b1;
                        out_r.pc        <= 64'(pc_r);
                        out_r.raw_instr <= iresp_s.data;
                        ireq_valid_r    <= 1'b0;
                        state_r         <= HOLD;
                    end else if (ireq_valid_r && redirect_valid && !iresp_s.data_ok) begin
                        pending_r    <= redirect_al_s;
                        ireq_valid_r <= 1'b1;
                        state_r      <= FLUSH;
                    end else begin
                        ireq_valid_r <= 1'b1;
                        state_r      <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect_valid || out_ready) begin
                        out_r.valid  <= 1'b0;
                        ireq_valid_r <= 1'b1;
                        state_r      <= FETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                FLUSH: begin
                    if (redirect_valid) begin
                        pending_r <= redirect_al_s;
                    end else begin
                        pending_r <= pending_r;
                    end
                    if (iresp_s.data_ok) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= FLUSH;
                    end
                end
                default: begin
                    out_r.valid  <= 1'b0;
                    ireq_valid_r <= 1'b0;
                    state_r      <= FETCH;
                end
            endcase
        end
    end

    assign ireq_valid = ireq_valid_r;
    assign ireq_addr  = pc_r;
    assign out_valid  = out_r.valid;
    assign out_pc     = out_r.pc[PC_W-1:0];
    assign out_instr  = out_r.raw_instr;

endmodule
